// File: rtl/mod_datapath_if.sv
//------------------------------------------------------------------------------
// mod_datapath_if : start/done request bus between execute stage and the
//                   iterative remainder/quotient datapath.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mod_datapath_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] quotient;
  logic             div_zero;

  modport master (
    output start, a_in, b_in,
    input  busy, done, remainder, quotient, div_zero
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, remainder, quotient, div_zero
  );
endinterface

`default_nettype wire

// File: rtl/mod_datapath.sv
//------------------------------------------------------------------------------
// mod_datapath : remainder/quotient registers driven by an external compare/
//                subtract controller; adds start/done handshake and restart.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mod_datapath #(
  parameter int WIDTH = 32
) (
  input  wire logic          CLK,
  input  wire logic          reset,
  mod_datapath_if.slave      bus,
  input  wire logic          i_we,
  input  wire logic          i_s,
  output logic               o_is_less,
  output logic               o_ctl_rst
);

  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_a_hold;
  logic [WIDTH-1:0] r_q;
  logic             r_loaded;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_remainder;
  logic [WIDTH-1:0] r_quotient;
  logic             r_div_zero;

  logic w_accept;
  logic w_b_zero;
  logic w_finish;

  assign w_accept  = bus.start & ~r_busy;
  assign w_b_zero  = (bus.b_in == '0);
  assign o_is_less = (r_r < r_b);
  assign o_ctl_rst = reset | (w_accept & ~w_b_zero);
  // The controller's compare cycle (we=0, s=1) with R<B ends the operation.
  assign w_finish  = r_busy & r_loaded & ~i_we & i_s & o_is_less;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_r         <= '0;
      r_b         <= '0;
      r_a_hold    <= '0;
      r_q         <= '0;
      r_loaded    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_remainder <= '0;
      r_quotient  <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (!w_b_zero) begin
          r_a_hold <= bus.a_in;
          r_b      <= bus.b_in;
          r_q      <= '0;
          r_loaded <= 1'b0;
          r_busy   <= 1'b1;
        end else begin
          r_done      <= 1'b1;
          r_div_zero  <= 1'b1;
          r_remainder <= bus.a_in;
          r_quotient  <= '1;
        end
      end else if (r_busy) begin
        if (i_we) begin
          if (!i_s) begin
            r_r      <= r_a_hold;
            r_loaded <= 1'b1;
          end else begin
            r_r <= r_r - r_b;
            r_q <= r_q + 1'b1;
          end
        end else if (w_finish) begin
          r_remainder <= r_r;
          r_quotient  <= r_q;
          r_div_zero  <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.remainder = r_remainder;
  assign bus.quotient  = r_quotient;
  assign bus.div_zero  = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_mod_datapath.sv
//------------------------------------------------------------------------------
// tb_mod_datapath : directed bench for mod_datapath with a behavioural
//                   load/compare/subtract controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod_datapath;

  localparam int WIDTH = 32;

  logic CLK;
  logic reset;
  logic we;
  logic s;
  logic is_less;
  logic ctl_rst;

  int tests_run;
  int tests_failed;

  mod_datapath_if #(.WIDTH(WIDTH)) bus ();

  mod_datapath #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .bus       (bus.slave),
    .i_we      (we),
    .i_s       (s),
    .o_is_less (is_less),
    .o_ctl_rst (ctl_rst)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Controller: load, then compare; subtract and compare again until R<B, then park.
  typedef enum logic [1:0] {C_LOAD, C_CMP, C_SUB, C_PARK} cst_t;
  cst_t r_cst;

  always_ff @(posedge CLK) begin
    if (ctl_rst) begin
      r_cst <= C_LOAD;
    end else begin
      case (r_cst)
        C_LOAD:  r_cst <= C_CMP;
        C_CMP:   r_cst <= is_less ? C_PARK : C_SUB;
        C_SUB:   r_cst <= C_CMP;
        default: r_cst <= C_PARK;
      endcase
    end
  end

  assign we = (r_cst == C_LOAD) || (r_cst == C_SUB);
  assign s  = (r_cst == C_CMP)  || (r_cst == C_SUB);

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a start in the current cycle (cycle 0), then wait for done.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int exp_cyc, input logic [WIDTH-1:0] exp_rem,
                        input logic [WIDTH-1:0] exp_quo, input logic exp_dz);
    int cyc;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    #1;
    check({tag, "_ctlrst_c0"}, WIDTH'(ctl_rst), WIDTH'(b != 0));
    tick();
    bus.start = 1'b0;
    #1;
    cyc = 1;
    check({tag, "_ctlrst_c1"}, WIDTH'(ctl_rst), '0);
    while (!bus.done && cyc <= exp_cyc + 4) begin
      check({tag, "_busy"}, WIDTH'(bus.busy), WIDTH'(b != 0));
      tick();
      cyc++;
    end
    check({tag, "_done_cycle"}, WIDTH'(cyc), WIDTH'(exp_cyc));
    check({tag, "_done"},       WIDTH'(bus.done), 1);
    check({tag, "_busy_done"},  WIDTH'(bus.busy), 0);
    check({tag, "_rem"},        bus.remainder, exp_rem);
    check({tag, "_quo"},        bus.quotient, exp_quo);
    check({tag, "_dz"},         WIDTH'(bus.div_zero), WIDTH'(exp_dz));
  endtask

  initial begin
    int cyc;
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    tick();
    tick();
    check("rst_ctlrst",  WIDTH'(ctl_rst), 1);
    check("rst_busy",    WIDTH'(bus.busy), 0);
    check("rst_done",    WIDTH'(bus.done), 0);
    check("rst_rem",     bus.remainder, 0);
    check("rst_quo",     bus.quotient, 0);
    check("rst_dz",      WIDTH'(bus.div_zero), 0);
    check("rst_isless",  WIDTH'(is_less), 0);
    reset = 1'b0;
    tick();
    tick();
    check("idle_done", WIDTH'(bus.done), 0);

    run_op("op17_5", 32'd17, 32'd5, 9, 32'd2, 32'd3, 1'b0);
    tick();
    check("op17_5_done_once", WIDTH'(bus.done), 0);
    tick();

    run_op("op3_7", 32'd3, 32'd7, 3, 32'd3, 32'd0, 1'b0);
    tick();

    run_op("op20_5", 32'd20, 32'd5, 11, 32'd0, 32'd4, 1'b0);
    run_op("op9_4_b2b", 32'd9, 32'd4, 7, 32'd1, 32'd2, 1'b0);
    tick();
    check("op9_4_done_once", WIDTH'(bus.done), 0);

    run_op("op12_0", 32'd12, 32'd0, 1, 32'd12, 32'hFFFF_FFFF, 1'b1);
    tick();

    // Start while busy is ignored.
    bus.a_in  = 32'd100;
    bus.b_in  = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 4) begin
      tick();
      cyc++;
    end
    bus.a_in  = 32'd50;
    bus.b_in  = 32'd7;
    bus.start = 1'b1;
    #1;
    check("ign_ctlrst", WIDTH'(ctl_rst), 0);
    tick();
    bus.start = 1'b0;
    cyc++;
    while (!bus.done && cyc <= 80) begin
      tick();
      cyc++;
    end
    check("ign_done_cycle", WIDTH'(cyc), 69);
    check("ign_rem",        bus.remainder, 32'd1);
    check("ign_quo",        bus.quotient, 32'd33);
    check("ign_dz",         WIDTH'(bus.div_zero), 0);
    tick();

    // Reset in the middle of an operation.
    bus.a_in  = 32'd100;
    bus.b_in  = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      tick();
      cyc++;
    end
    reset = 1'b1;
    #1;
    check("mid_rst_ctlrst", WIDTH'(ctl_rst), 1);
    tick();
    reset = 1'b0;
    check("mid_rst_busy", WIDTH'(bus.busy), 0);
    check("mid_rst_rem",  bus.remainder, 0);
    check("mid_rst_quo",  bus.quotient, 0);
    check("mid_rst_done", WIDTH'(bus.done), 0);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.done) check("mid_rst_no_done", WIDTH'(bus.done), 0);
    end
    check("mid_rst_idle_busy", WIDTH'(bus.busy), 0);
    run_op("op8_3", 32'd8, 32'd3, 7, 32'd2, 32'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_datapath.md
Name: mod_datapath

Overview:
- Iterative remainder/quotient datapath paired with the mod control FSM (inputs `we`, `s`; outputs `is_less`).
- Holds the working remainder, divisor and quotient counter, and exposes `is_less` to the controller.
- Provides a start/done handshake toward the ALU/execute stage.
- Restarts the controller through `ctl_rst`, since the controller parks in its final state until reset.

Parameters:
- WIDTH, 32, operand/result width in bits (unsigned).

Ports:
- CLK  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- a_in  input  WIDTH  dividend, sampled with an accepted start.
- b_in  input  WIDTH  divisor, sampled with an accepted start.
- we  input  1  controller write enable for the remainder/quotient registers.
- s  input  1  controller select: 0 = load dividend, 1 = subtract divisor.
- is_less  output  1  to controller: R < B, unsigned.
- ctl_rst  output  1  controller reset.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- remainder  output  WIDTH  final remainder, held until next completion.
- quotient  output  WIDTH  final quotient, held until next completion.
- div_zero  output  1  last operation had b_in==0; valid with done, held afterwards.

Behaviour:
- Reset is synchronous, active-high; clock CLK.
- Reset values: busy=0, done=0, remainder=0, quotient=0, div_zero=0.
- Internal reset values: R=0, B=0, A_hold=0, Q=0, loaded=0.
- ctl_rst is combinational: reset | (start & ~busy & b_in!=0). It puts the controller in its load state on the next edge.
- Start acceptance: start & ~busy.
  - b_in!=0: A_hold<=a_in, B<=b_in, Q<=0, loaded<=0, busy<=1.
  - b_in==0: no controller restart. Next cycle done=1, div_zero=1, remainder=a_in, quotient={WIDTH{1'b1}}, busy stays 0.
  - start while busy=1 is ignored; no operand capture, no ctl_rst.
- Register writes occur only while busy=1 and we=1:
  - s=0: R<=A_hold, loaded<=1.
  - s=1: R<=R-B (WIDTH-bit, no wrap possible because R>=B is guaranteed), Q<=Q+1.
- we/s are ignored while busy=0, so a parked controller cannot corrupt R or Q.
- is_less = (R < B) unsigned, combinational from registers, driven at all times.
- Completion when busy & loaded & ~we & s & is_less (controller compare cycle with R<B). At that edge:
  - remainder<=R, quotient<=Q, div_zero<=0, busy<=0.
  - done=1 for exactly the following cycle.
- Timing, start accepted in cycle 0:
  - cycle 1: load.
  - cycle 2: first compare.
  - each unsuccessful compare adds 2 cycles (subtract, compare).
  - done in cycle 3+2·Q_final.
- done is never asserted in two consecutive cycles. A new start may be accepted in the same cycle done is high (busy=0).
- Reset mid-operation: all state returns to reset values next edge, ctl_rst=1 during reset, no done pulse generated.
- Latency is unbounded by design: B=1, A=2^WIDTH-1 takes 2^(WIDTH+1)+1 cycles. Callers are responsible for operand range.

Test Plan:
- a_in=17, b_in=5, start 1 cycle -> busy=1 cycles 1..8; done=1 at cycle 9, remainder=2, quotient=3, div_zero=0.
- a_in=3, b_in=7 -> done at cycle 3, remainder=3, quotient=0; ctl_rst high only in cycle 0.
- a_in=20, b_in=5 (exact), then back-to-back start a_in=9, b_in=4 in the done cycle:
  - first op: done at cycle 11, remainder=0, quotient=4.
  - second op: done 7 cycles later, remainder=1, quotient=2.
- a_in=12, b_in=0 -> no ctl_rst, busy stays 0; done at cycle 1, div_zero=1, remainder=12, quotient=0xFFFFFFFF.
- Start 100/3 with a second start (50/7) asserted in cycle 4 -> second start ignored; done at cycle 69, remainder=1, quotient=33.
- Start 100/3, assert reset in cycle 10 for one cycle -> busy=0, remainder=0, quotient=0, no done. A following 8/3 completes with remainder=2, quotient=2 at cycle 7.
